// File: rtl/vga_pkg.sv
// Shared VGA raster defaults, pixel/pipeline types and the RGB332 -> RGB888 expansion.
package vga_pkg;

  localparam int CLK_DIV_DEF  = 2;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int IMG_W_DEF    = 256;
  localparam int IMG_H_DEF    = 256;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Stage-0 decode carried one tick forward to line up with the memory read.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic de;
    logic img;
    logic org;
  } stage_t;

  typedef struct packed {
    logic    hs_n;
    logic    vs_n;
    logic    de;
    logic    fs;
    rgb888_t rgb;
  } pins_t;

  localparam stage_t STAGE_RST = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, img: 1'b0, org: 1'b0};
  localparam pins_t  PINS_RST  = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, fs: 1'b0, rgb: '0};

  function automatic rgb888_t expand332(input rgb332_t p);
    rgb888_t c;
    c.r = {p.r, p.r, p.r[2:1]};
    c.g = {p.g, p.g, p.g[2:1]};
    c.b = {p.b, p.b, p.b, p.b};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider and raster counters with combinational stage-0 sync/active decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(HT),
  localparam int VW = $clog2(VT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hs_n,
  output logic          vs_n,
  output logic          active
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    tick   = (div_q == '0);
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign hs_n   = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
  assign vs_n   = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
  assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

endmodule

// File: rtl/vga_frame_reader.sv
// Scans an RGB332 image buffer out to VGA at the raster's top-left corner, black elsewhere.
// Stage 0 issues the read on a tick; stage 1 drives all pins one tick later with the returned pixel.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              img_valid,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int IW = $clog2(IMG_W);
  localparam int YW = ADDR_W - IW;
  localparam logic [HW-1:0] IMG_W_H = HW'(IMG_W);
  localparam logic [VW-1:0] IMG_H_V = VW'(IMG_H);

  logic          tick, hs_n, vs_n, active;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  vga_timing #(
    .CLK_DIV (CLK_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .hcnt  (hcnt),
    .vcnt  (vcnt),
    .hs_n  (hs_n),
    .vs_n  (vs_n),
    .active(active)
  );

  logic in_img, at_origin;
  assign in_img    = (hcnt < IMG_W_H) && (vcnt < IMG_H_V);
  assign at_origin = (hcnt == '0) && (vcnt == '0);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              show_q, show_d;
  stage_t            s0_q, s0_d;
  pins_t             out_q, out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rd_q   <= 1'b0;
      show_q <= 1'b0;
      s0_q   <= STAGE_RST;
      out_q  <= PINS_RST;
    end else begin
      addr_q <= addr_d;
      rd_q   <= rd_d;
      show_q <= show_d;
      s0_q   <= s0_d;
      out_q  <= out_d;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    rd_d     = 1'b0;
    show_d   = show_q;
    s0_d     = s0_q;
    out_d    = out_q;
    out_d.fs = 1'b0;
    if (tick) begin
      rd_d = in_img;
      // Address holds outside the image, so it never runs past the last pixel.
      if (in_img) addr_d = {vcnt[YW-1:0], hcnt[IW-1:0]};
      if (at_origin) show_d = img_valid;
      s0_d = '{hs_n: hs_n, vs_n: vs_n, de: active, img: in_img, org: at_origin};
      out_d.hs_n = s0_q.hs_n;
      out_d.vs_n = s0_q.vs_n;
      out_d.de   = s0_q.de;
      out_d.fs   = s0_q.org;
      // show_q here is still the value latched for the frame the stage-0 pixel belongs to.
      out_d.rgb  = (s0_q.img && show_q) ? expand332(rgb332_t'(mem_rdata)) : '0;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign vga_hs      = out_q.hs_n;
  assign vga_vs      = out_q.vs_n;
  assign vga_de      = out_q.de;
  assign vga_r       = out_q.rgb.r;
  assign vga_g       = out_q.rgb.g;
  assign vga_b       = out_q.rgb.b;
  assign frame_start = out_q.fs;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken raster, checked against a per-tick frame model.
`timescale 1ns/1ps
module tb_vga_frame_reader;

  localparam int CLK_DIV = 2;
  localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_ACTIVE = 20, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int IMG_W = 16, IMG_H = 16, ADDR_W = 8;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              img_valid = 1'b0;
  logic [7:0]        mem_rdata = 8'h00;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, vga_hs, vga_vs, vga_de, frame_start;
  logic [7:0]        vga_r, vga_g, vga_b;

  logic [7:0] mem [IMG_W*IMG_H];

  int n_vec = 0;
  int n_bad = 0;
  int n = -1;
  logic show_cur = 1'b0, show_out = 1'b0, fs_b = 1'b0;

  logic e_hs, e_vs, e_de, e_fs, e_rd;
  logic [7:0] e_r, e_g, e_b;
  int e_addr;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  vga_frame_reader #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .img_valid(img_valid), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  // Reference: after tick edge k the pins show raster pixel k-1 and stage 0 holds pixel k.
  task automatic model(input int k);
    int p, h, v, r3, g3, b2;
    logic [7:0] c;
    if (k == 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
      e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
    end else begin
      p = (k - 1) % FRAME; h = p % HT; v = p / HT;
      e_hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
      e_vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      e_de = (h < H_ACTIVE) && (v < V_ACTIVE);
      e_fs = (p == 0);
      e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
      if (h < IMG_W && v < IMG_H && show_out) begin
        c  = mem[v * IMG_W + h];
        r3 = int'(c[7:5]); g3 = int'(c[4:2]); b2 = int'(c[1:0]);
        e_r = 8'(r3 * 36 + r3 / 2);
        e_g = 8'(g3 * 36 + g3 / 2);
        e_b = 8'(b2 * 85);
      end
    end
    p = k % FRAME; h = p % HT; v = p / HT;
    e_rd   = (h < IMG_W) && (v < IMG_H);
    e_addr = v * IMG_W + h;
  endtask

  // Advance one pixel tick; returns 1ns after the tick edge.
  task automatic adv();
    logic iv;
    if (n >= 0) begin
      @(posedge clk); #1;
      fs_b = frame_start;
    end
    iv = img_valid;
    @(posedge clk); #1;
    n++;
    show_out = show_cur;
    if (n % FRAME == 0) show_cur = iv;
    model(n);
  endtask

  task automatic goto(input int pos);
    adv();
    for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) adv();
  endtask

  task automatic fill_random();
    for (int i = 0; i < IMG_W*IMG_H; i++) mem[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    fill_random();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n = -1; show_cur = 1'b0;
    goto(2 * HT + 5 + $urandom_range(0, 8));
    #2 rst = 1'b1;
    #1;
    n_vec++; if (vga_hs !== 1'b1) begin n_bad++; $display("FAIL reset_hs got %b want 1", vga_hs); end
    n_vec++; if (vga_vs !== 1'b1) begin n_bad++; $display("FAIL reset_vs got %b want 1", vga_vs); end
    n_vec++; if (vga_de !== 1'b0) begin n_bad++; $display("FAIL reset_de got %b want 0", vga_de); end
    n_vec++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin n_bad++; $display("FAIL reset_rgb got %h want 0", {vga_r, vga_g, vga_b}); end
    n_vec++; if (mem_rd !== 1'b0 || mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem got rd=%b addr=%0d want 0/0", mem_rd, mem_addr); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n = -1; show_cur = 1'b0;
    adv();
    n_vec++; if (frame_start !== 1'b0 || vga_de !== 1'b0 || vga_hs !== 1'b1) begin
      n_bad++; $display("FAIL reset_tick0 got fs=%b de=%b hs=%b want 0/0/1", frame_start, vga_de, vga_hs);
    end
    adv();
    n_vec++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL reset_first_fs got %b want 1", frame_start); end
    n_vec++; if (vga_de !== 1'b1) begin n_bad++; $display("FAIL reset_first_de got %b want 1", vga_de); end
    adv();
    n_vec++; if (fs_b !== 1'b0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs_width got %b/%b want 0/0", fs_b, frame_start); end
  endtask

  task automatic test_sync_widths();
    int hs_low = 0, vs_low = 0, de_hi = 0;
    int hfall = -1, vfall = -1, hrun = 0, vrun = 0;
    logic phs, pvs;
    phs = vga_hs; pvs = vga_vs;
    for (int i = 0; i < 2 * FRAME; i++) begin
      adv();
      n_vec++; if (vga_hs !== e_hs) begin n_bad++; $display("FAIL sync_hs n=%0d got %b want %b", n, vga_hs, e_hs); end
      n_vec++; if (vga_vs !== e_vs) begin n_bad++; $display("FAIL sync_vs n=%0d got %b want %b", n, vga_vs, e_vs); end
      n_vec++; if (vga_de !== e_de) begin n_bad++; $display("FAIL sync_de n=%0d got %b want %b", n, vga_de, e_de); end
      if (i < FRAME) begin
        hs_low += int'(!vga_hs); vs_low += int'(!vga_vs); de_hi += int'(vga_de);
      end
      if (phs && !vga_hs) begin
        if (hfall >= 0) begin
          n_vec++; if (i - hfall != HT) begin n_bad++; $display("FAIL hs_period got %0d want %0d", i - hfall, HT); end
        end
        hfall = i; hrun = 0;
      end
      if (!vga_hs) hrun++;
      if (!phs && vga_hs && hfall >= 0) begin
        n_vec++; if (hrun != H_SYNC) begin n_bad++; $display("FAIL hs_width got %0d want %0d", hrun, H_SYNC); end
      end
      if (pvs && !vga_vs) begin
        if (vfall >= 0) begin
          n_vec++; if (i - vfall != FRAME) begin n_bad++; $display("FAIL vs_period got %0d want %0d", i - vfall, FRAME); end
        end
        vfall = i; vrun = 0;
      end
      if (!vga_vs) vrun++;
      if (!pvs && vga_vs && vfall >= 0) begin
        n_vec++; if (vrun != V_SYNC * HT) begin n_bad++; $display("FAIL vs_width got %0d want %0d", vrun, V_SYNC * HT); end
      end
      phs = vga_hs; pvs = vga_vs;
    end
    n_vec++; if (hs_low != VT * H_SYNC) begin n_bad++; $display("FAIL hs_low_total got %0d want %0d", hs_low, VT * H_SYNC); end
    n_vec++; if (vs_low != V_SYNC * HT) begin n_bad++; $display("FAIL vs_low_total got %0d want %0d", vs_low, V_SYNC * HT); end
    n_vec++; if (de_hi != H_ACTIVE * V_ACTIVE) begin n_bad++; $display("FAIL de_total got %0d want %0d", de_hi, H_ACTIVE * V_ACTIVE); end
  endtask

  task automatic test_fetch();
    img_valid = 1'b1;
    goto(20 * HT);
    mem[3 * IMG_W + 10] = 8'hE0;
    goto(0);
    goto(3 * HT + 10);
    n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 8'd58) begin
      n_bad++; $display("FAIL fetch_addr got rd=%b addr=%0d want 1/58", mem_rd, mem_addr);
    end
    adv();
    n_vec++; if ({vga_r, vga_g, vga_b} !== 24'hFF0000 || vga_de !== 1'b1) begin
      n_bad++; $display("FAIL fetch_rgb got %h de=%b want ff0000 de=1", {vga_r, vga_g, vga_b}, vga_de);
    end
  endtask

  task automatic test_outside();
    goto(5 * HT + 20);
    n_vec++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL outside_h_rd got %b want 0", mem_rd); end
    adv();
    n_vec++; if (vga_de !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h0) begin
      n_bad++; $display("FAIL outside_h_rgb got de=%b rgb=%h want 1/0", vga_de, {vga_r, vga_g, vga_b});
    end
    goto(17 * HT + 5);
    n_vec++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL outside_v_rd got %b want 0", mem_rd); end
    adv();
    n_vec++; if (vga_de !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h0) begin
      n_bad++; $display("FAIL outside_v_rgb got de=%b rgb=%h want 1/0", vga_de, {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_last_pixel();
    goto((IMG_H - 1) * HT + IMG_W - 1);
    n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 8'd255) begin
      n_bad++; $display("FAIL last_addr got rd=%b addr=%0d want 1/255", mem_rd, mem_addr);
    end
    adv();
    n_vec++; if (mem_rd !== 1'b0 || mem_addr !== 8'd255) begin
      n_bad++; $display("FAIL last_nowrap got rd=%b addr=%0d want 0/255", mem_rd, mem_addr);
    end
    n_vec++; if ({vga_r, vga_g, vga_b} !== {e_r, e_g, e_b}) begin
      n_bad++; $display("FAIL last_rgb got %h want %h", {vga_r, vga_g, vga_b}, {e_r, e_g, e_b});
    end
  endtask

  task automatic test_frame_latch();
    img_valid = 1'b0;
    goto(20 * HT);
    for (int i = 0; i < IMG_W*IMG_H; i++) mem[i] = 8'h1F;
    goto(0);
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10 * HT) img_valid = 1'b1;
      adv();
      n_vec++; if ({vga_r, vga_g, vga_b} !== 24'h0 || {e_r, e_g, e_b} !== 24'h0) begin
        n_bad++; $display("FAIL latch_black n=%0d got %h model %h want 0", n, {vga_r, vga_g, vga_b}, {e_r, e_g, e_b});
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i == 3 * HT) img_valid = 1'($urandom_range(0, 1));
      adv();
      if (i == 0) begin
        n_vec++; if ({vga_r, vga_g, vga_b} !== 24'h00FFFF) begin
          n_bad++; $display("FAIL latch_show got %h want 00ffff", {vga_r, vga_g, vga_b});
        end
      end
      n_vec++; if ({vga_r, vga_g, vga_b} !== {e_r, e_g, e_b}) begin
        n_bad++; $display("FAIL latch_frame n=%0d got %h want %h", n, {vga_r, vga_g, vga_b}, {e_r, e_g, e_b});
      end
    end
  endtask

  task automatic test_back_to_back();
    goto(20 * HT);
    fill_random();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((n % FRAME) == 8 * HT) img_valid = 1'($urandom_range(0, 1));
      adv();
      n_vec++; if ({vga_hs, vga_vs, vga_de} !== {e_hs, e_vs, e_de}) begin
        n_bad++; $display("FAIL b2b_sync n=%0d got %b want %b", n, {vga_hs, vga_vs, vga_de}, {e_hs, e_vs, e_de});
      end
      n_vec++; if ({vga_r, vga_g, vga_b} !== {e_r, e_g, e_b}) begin
        n_bad++; $display("FAIL b2b_rgb n=%0d got %h want %h", n, {vga_r, vga_g, vga_b}, {e_r, e_g, e_b});
      end
      n_vec++; if (frame_start !== e_fs || fs_b !== 1'b0) begin
        n_bad++; $display("FAIL b2b_fs n=%0d got %b/%b want %b/0", n, frame_start, fs_b, e_fs);
      end
      n_vec++; if (mem_rd !== e_rd) begin
        n_bad++; $display("FAIL b2b_rd n=%0d got %b want %b", n, mem_rd, e_rd);
      end
      if (e_rd) begin
        n_vec++; if (mem_addr !== ADDR_W'(e_addr)) begin
          n_bad++; $display("FAIL b2b_addr n=%0d got %0d want %0d", n, mem_addr, e_addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_widths();
    test_fetch();
    test_outside();
    test_last_pixel();
    test_frame_latch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
